// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts decoded MIPS field tuples over a
// valid/ready handshake, packs each one into a 32-bit instruction word and
// writes the words to consecutive instruction-memory addresses.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            restart the load (honoured in IDLE, DONE, ERR)
//   in_valid/ready   tuple handshake; in_kind selects the format
//   in_rs..in_last   tuple fields; in_last marks the final instruction
//   mem_we/addr/     memory write port, held until mem_ready is high
//   mem_wdata/ready
//   count            words written since reset/start
//   done, err        sticky completion / error status
//   err_code         00 none, 01 illegal kind, 10 address overflow
module instr_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ENC  = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] TOP      = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic [2:0]  state, stateNext;
  logic [3:0]  kindQ;
  logic [4:0]  rsQ, rtQ, rdQ, shamtQ;
  logic [5:0]  functQ;
  logic [15:0] immQ;
  logic [25:0] targetQ;
  logic        lastQ;

  logic              loadFields;
  logic              readyNext, weNext, doneNext, errNext;
  logic [ADDR_W-1:0] addrNext;
  logic [31:0]       wdataNext;
  logic [ADDR_W:0]   countNext;
  logic [1:0]        codeNext;
  logic [31:0]       encWord;

  // Pack the latched fields according to the latched kind.
  always_comb begin
    encWord = 32'h0;
    case (kindQ)
      4'd0: encWord = {6'b000000, rsQ, rtQ, rdQ, shamtQ, functQ};
      4'd1: encWord = {6'b101011, rsQ, rtQ, immQ};
      4'd2: encWord = {6'b100011, rsQ, rtQ, immQ};
      4'd3: encWord = {6'b001101, rsQ, rtQ, immQ};
      4'd4: encWord = {6'b001100, rsQ, rtQ, immQ};
      4'd5: encWord = {6'b001000, rsQ, rtQ, immQ};
      4'd6: encWord = {6'b000100, rsQ, rtQ, immQ};
      4'd7: encWord = {6'b000010, targetQ};
      default: encWord = 32'h0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    stateNext  = state;
    loadFields = 1'b0;
    readyNext  = in_ready;
    weNext     = mem_we;
    addrNext   = mem_addr;
    wdataNext  = mem_wdata;
    countNext  = count;
    doneNext   = done;
    errNext    = err;
    codeNext   = err_code;
    case (state)
      IDLE: begin
        if (start) begin
          // start beats a simultaneous tuple
          addrNext  = BASE;
          countNext = '0;
          doneNext  = 1'b0;
          errNext   = 1'b0;
          codeNext  = 2'b00;
          readyNext = 1'b1;
        end else if (in_valid && in_ready) begin
          loadFields = 1'b1;
          readyNext  = 1'b0;
          stateNext  = ENC;
        end else begin
          readyNext = 1'b1;
        end
      end
      ENC: begin
        if (kindQ[3]) begin
          stateNext = ERR;
          errNext   = 1'b1;
          codeNext  = 2'b01;
        end else begin
          wdataNext = encWord;
          weNext    = 1'b1;
          stateNext = WR;
        end
      end
      WR: begin
        if (mem_ready) begin
          weNext    = 1'b0;
          countNext = count + CNT_ONE;
          addrNext  = mem_addr + ADDR_ONE;
          if (lastQ) begin
            stateNext = DONE;
            doneNext  = 1'b1;
          end else if (mem_addr == TOP) begin
            stateNext = ERR;
            errNext   = 1'b1;
            codeNext  = 2'b10;
          end else begin
            stateNext = IDLE;
            readyNext = 1'b1;
          end
        end
      end
      DONE, ERR: begin
        readyNext = 1'b0;
        weNext    = 1'b0;
        if (start) begin
          stateNext = IDLE;
          addrNext  = BASE;
          countNext = '0;
          doneNext  = 1'b0;
          errNext   = 1'b0;
          codeNext  = 2'b00;
          readyNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        readyNext = 1'b0;
        weNext    = 1'b0;
      end
    endcase
  end

  // State, output and field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= 32'h0;
      count     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
      kindQ     <= 4'h0;
      rsQ       <= 5'h0;
      rtQ       <= 5'h0;
      rdQ       <= 5'h0;
      shamtQ    <= 5'h0;
      functQ    <= 6'h0;
      immQ      <= 16'h0;
      targetQ   <= 26'h0;
      lastQ     <= 1'b0;
    end else begin
      state     <= stateNext;
      in_ready  <= readyNext;
      mem_we    <= weNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      count     <= countNext;
      done      <= doneNext;
      err       <= errNext;
      err_code  <= codeNext;
      if (loadFields) begin
        kindQ   <= in_kind;
        rsQ     <= in_rs;
        rtQ     <= in_rt;
        rdQ     <= in_rd;
        shamtQ  <= in_shamt;
        functQ  <= in_funct;
        immQ    <= in_imm;
        targetQ <= in_target;
        lastQ   <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: an ADDR_W=8 instance for encoding,
// handshake and stall behaviour, and an ADDR_W=2 instance for overflow
// and reset-during-stall behaviour.
module tb_instr_encoder_loader;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;
    logic        restart;
    logic [31:0] word;
  } vec_t;

  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  cnt;
    logic        done;
    logic        err;
    logic [1:0]  code;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, start, inValid, memReady;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;

  logic        rdy0, we0, done0, err0, rdy1, we1, done1, err1;
  logic [7:0]  addr0;
  logic [1:0]  addr1;
  logic [31:0] wdata0, wdata1;
  logic [8:0]  cnt0;
  logic [2:0]  cnt1;
  logic [1:0]  code0, code1;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .in_valid(inValid[0]), .in_ready(rdy0),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
    .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_ready(memReady[0]),
    .count(cnt0), .done(done0), .err(err0), .err_code(code0));

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .in_valid(inValid[1]), .in_ready(rdy1),
    .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(shamt),
    .in_funct(funct), .in_imm(imm), .in_target(target), .in_last(last),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_ready(memReady[1]),
    .count(cnt1), .done(done1), .err(err1), .err_code(code1));

  int   tests = 0;
  int   failed = 0;
  int   expAddr[2];
  int   expCnt[2];
  obs_t cur;
  vec_t tbl[8];

  function automatic obs_t pick(input int sel);
    obs_t o;
    if (sel == 0) o = '{rdy0, we0, addr0, wdata0, cnt0, done0, err0, code0};
    else          o = '{rdy1, we1, 8'(addr1), wdata1, 9'(cnt1), done1, err1, code1};
    return o;
  endfunction

  task automatic tick(input int sel);
    @(posedge clk);
    #1;
    cur = pick(sel);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chkStatus(input string name, input int sel, input logic dn,
                           input logic er, input logic [1:0] cd);
    cur = pick(sel);
    chk({name, "_cnt"},  32'(cur.cnt),  32'(expCnt[sel]));
    chk({name, "_addr"}, 32'(cur.addr), 32'(expAddr[sel]));
    chk({name, "_done"}, 32'(cur.done), 32'(dn));
    chk({name, "_err"},  32'(cur.err),  32'(er));
    chk({name, "_code"}, 32'(cur.code), 32'(cd));
  endtask

  task automatic pulseStart(input int sel);
    start[sel] = 1'b1;
    tick(sel);
    start[sel] = 1'b0;
    expAddr[sel] = 0;
    expCnt[sel]  = 0;
    chkStatus("restart", sel, 1'b0, 1'b0, 2'b00);
    chk("restart_rdy", 32'(cur.rdy), 32'd1);
  endtask

  // Accept one tuple, follow it through ENC and WR with an optional stall.
  task automatic sendTuple(input int sel, input vec_t v, input int stall);
    int n = 0;
    cur = pick(sel);
    while (!cur.rdy && n < 20) begin
      tick(sel);
      n++;
    end
    if (!cur.rdy) begin
      chk("rdy_wait", 32'(cur.rdy), 32'd1);
      return;
    end
    kind = v.kind; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
    funct = v.funct; imm = v.imm; target = v.target; last = v.last;
    inValid[sel]  = 1'b1;
    memReady[sel] = (stall == 0);
    tick(sel);
    inValid[sel] = 1'b0;
    chk("enc_rdy", 32'(cur.rdy), 32'd0);
    chk("enc_we",  32'(cur.we),  32'd0);
    tick(sel);
    chk("wr_we",    32'(cur.we),    32'd1);
    chk("wr_addr",  32'(cur.addr),  32'(expAddr[sel]));
    chk("wr_wdata", cur.wdata,      v.word);
    for (int i = 0; i < stall; i++) begin
      tick(sel);
      chk("stall_we",    32'(cur.we),   32'd1);
      chk("stall_addr",  32'(cur.addr), 32'(expAddr[sel]));
      chk("stall_wdata", cur.wdata,     v.word);
      chk("stall_cnt",   32'(cur.cnt),  32'(expCnt[sel]));
    end
    memReady[sel] = 1'b1;
    tick(sel);
    expCnt[sel]++;
    expAddr[sel] = (expAddr[sel] + 1) % (sel == 0 ? 256 : 4);
    chk("post_we",   32'(cur.we),   32'd0);
    chk("post_cnt",  32'(cur.cnt),  32'(expCnt[sel]));
    chk("post_addr", 32'(cur.addr), 32'(expAddr[sel]));
  endtask

  initial begin
    vec_t addi;
    vec_t bad;
    rst = 2'b11; start = 2'b00; inValid = 2'b00; memReady = 2'b11;
    kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    imm = '0; target = '0; last = 1'b0;
    expAddr = '{0, 0};
    expCnt  = '{0, 0};

    //          kind  rs     rt     rd     shamt  funct  imm       target       last restart word
    tbl[0] = '{4'd5, 5'd0, 5'd8, 5'd31, 5'd7, 6'h3F, 16'h0005, 26'h3FFFFFF, 1'b0, 1'b0, 32'h20080005};
    tbl[1] = '{4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'hFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 32'h01095020};
    tbl[2] = '{4'd1, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0004, 26'h0,       1'b0, 1'b0, 32'hAD090004};
    tbl[3] = '{4'd2, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0004, 26'h0,       1'b0, 1'b0, 32'h8D090004};
    tbl[4] = '{4'd3, 5'd1, 5'd2, 5'd0,  5'd0, 6'h0,  16'h00FF, 26'h0,       1'b0, 1'b1, 32'h342200FF};
    tbl[5] = '{4'd4, 5'd3, 5'd4, 5'd5,  5'd6, 6'h1,  16'hF0F0, 26'h0,       1'b0, 1'b0, 32'h3064F0F0};
    tbl[6] = '{4'd6, 5'd8, 5'd9, 5'd0,  5'd0, 6'h0,  16'hFFFF, 26'h0,       1'b0, 1'b1, 32'h1109FFFF};
    tbl[7] = '{4'd7, 5'd31,5'd31,5'd31, 5'd31,6'h3F, 16'hFFFF, 26'h0100000, 1'b1, 1'b0, 32'h08100000};

    tick(0);
    tick(0);
    rst = 2'b00;
    chkStatus("reset0", 0, 1'b0, 1'b0, 2'b00);
    chk("reset0_rdy",   32'(cur.rdy),   32'd0);
    chk("reset0_we",    32'(cur.we),    32'd0);
    chk("reset0_wdata", cur.wdata,      32'd0);
    chkStatus("reset1", 1, 1'b0, 1'b0, 2'b00);
    tick(0);
    chk("rdy_after_reset", 32'(cur.rdy), 32'd1);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].restart) pulseStart(0);
      sendTuple(0, tbl[i], 0);
      chk("rdy_back", 32'(cur.rdy), 32'(!tbl[i].last));
    end
    chkStatus("done_seq", 0, 1'b1, 1'b0, 2'b00);
    tick(0);
    chk("done_hold_rdy", 32'(cur.rdy), 32'd0);
    chkStatus("done_hold", 0, 1'b1, 1'b0, 2'b00);
    pulseStart(0);

    // Stalled write: outputs hold for 5 cycles, one count increment after.
    addi = tbl[0];
    sendTuple(0, addi, 5);

    // start together with in_valid in IDLE: start wins.
    kind = 4'd5; last = 1'b0;
    inValid[0] = 1'b1;
    start[0] = 1'b1;
    tick(0);
    start[0] = 1'b0;
    inValid[0] = 1'b0;
    expAddr[0] = 0; expCnt[0] = 0;
    chk("start_wins_rdy", 32'(cur.rdy), 32'd1);
    chkStatus("start_wins", 0, 1'b0, 1'b0, 2'b00);
    tick(0);
    chk("start_wins_we", 32'(cur.we), 32'd0);

    // Illegal kind: no write, sticky error until start.
    bad = tbl[0];
    bad.kind = 4'd9;
    kind = bad.kind;
    inValid[0] = 1'b1;
    tick(0);
    inValid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(0);
      chk("illegal_we",  32'(cur.we),  32'd0);
      chk("illegal_rdy", 32'(cur.rdy), 32'd0);
    end
    chkStatus("illegal", 0, 1'b0, 1'b1, 2'b01);
    pulseStart(0);

    // Overflow on the 2-bit instance.
    for (int i = 0; i < 4; i++) sendTuple(1, addi, 0);
    chkStatus("overflow", 1, 1'b0, 1'b1, 2'b10);
    chk("overflow_rdy", 32'(cur.rdy), 32'd0);
    pulseStart(1);
    for (int i = 0; i < 4; i++) begin
      addi.last = (i == 3);
      sendTuple(1, addi, 0);
    end
    chkStatus("last_at_top", 1, 1'b1, 1'b0, 2'b00);
    pulseStart(1);

    // Reset during a stalled write.
    addi.last = 1'b0;
    inValid[1] = 1'b1;
    memReady[1] = 1'b0;
    kind = addi.kind; rs = addi.rs; rt = addi.rt; imm = addi.imm; last = 1'b0;
    tick(1);
    inValid[1] = 1'b0;
    tick(1);
    tick(1);
    chk("pre_rst_we", 32'(cur.we), 32'd1);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0;
    memReady[1] = 1'b1;
    expAddr[1] = 0; expCnt[1] = 0;
    chk("rst_stall_we",    32'(cur.we),    32'd0);
    chk("rst_stall_wdata", cur.wdata,      32'd0);
    chk("rst_stall_rdy",   32'(cur.rdy),   32'd0);
    chkStatus("rst_stall", 1, 1'b0, 1'b0, 2'b00);
    tick(1);
    chk("rst_stall_rdy_next", 32'(cur.rdy), 32'd1);
    chk("rst_stall_we_next",  32'(cur.we),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
